// File: rtl/mdw_loader.sv
// Frame loader for the unpaired-word finder: writes N words into the finder table,
// starts one sweep and returns its result. Optional XOR cross-check: MDW_LOADER_XOR_CHECK_EN.
`timescale 1ns/1ps
module mdw_loader #(
   parameter int W = 5,
   parameter int N = 17
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_vld,
   input  logic [W-1:0]         in_dat,
   output logic                 in_rdy,
   output logic                 state_upt,
   output logic [$clog2(N)-1:0] state_id,
   output logic [W-1:0]         state_dat,
   output logic                 cntrl_start,
   input  logic                 cntrl_busy_r,
   input  logic [W-1:0]         cntrl_dat_r,
   output logic                 res_vld_r,
   input  logic                 res_rdy,
   output logic [W-1:0]         res_dat_r,
   output logic                 res_err_r
);

   localparam int IW = $clog2(N);

   typedef enum logic [1:0] {LOAD, START, WAIT, RESULT} state_t;

   state_t          state_r, state_nxt;
   logic [IW-1:0]   wr_ptr_r;
   logic            wait_armed_r;
   logic            in_xfer;
   logic            res_xfer;
   logic            last_word;
   logic            capture;

   assign in_xfer   = in_vld & in_rdy;
   assign res_xfer  = res_vld_r & res_rdy;
   assign last_word = (wr_ptr_r == IW'(N - 1));
   // The finder needs one edge to raise busy, so the first WAIT cycle is never a capture cycle.
   assign capture   = (state_r == WAIT) & wait_armed_r & ~cntrl_busy_r;

   assign state_upt = in_xfer & rst_n;
   assign state_id  = wr_ptr_r;
   assign state_dat = in_dat;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= LOAD;
      else        state_r <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt   = state_r;
      in_rdy      = 1'b0;
      cntrl_start = 1'b0;
      case (state_r)
         LOAD: begin
            in_rdy = 1'b1;
            if (in_xfer && last_word) state_nxt = START;
         end
         START: begin
            cntrl_start = 1'b1;
            state_nxt   = WAIT;
         end
         WAIT: begin
            if (capture) state_nxt = RESULT;
         end
         RESULT: begin
            if (res_xfer) state_nxt = LOAD;
         end
         default: state_nxt = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r     <= '0;
         wait_armed_r <= 1'b0;
         res_vld_r    <= 1'b0;
         res_dat_r    <= '0;
      end else begin
         if (in_xfer) wr_ptr_r <= last_word ? '0 : wr_ptr_r + 1'b1;
         wait_armed_r <= (state_r == WAIT);
         if (capture) begin
            res_vld_r <= 1'b1;
            res_dat_r <= cntrl_dat_r;
         end else if (res_xfer) begin
            res_vld_r <= 1'b0;
         end
      end
   end

`ifdef MDW_LOADER_XOR_CHECK_EN
   logic [W-1:0] acc_r;

   // A well-formed frame XORs down to its unpaired word, which must match the finder.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r     <= '0;
         res_err_r <= 1'b0;
      end else begin
         if (res_xfer)     acc_r <= '0;
         else if (in_xfer) acc_r <= acc_r ^ in_dat;
         if (capture) res_err_r <= (acc_r != cntrl_dat_r);
      end
   end
`else
   assign res_err_r = 1'b0;
`endif

endmodule

// File: tb/tb_mdw_loader.sv
// Directed bench for mdw_loader: small (N=5,W=4) and default (N=17,W=5) instances,
// each driven against a behavioural finder that reports the first odd-count table word.
`timescale 1ns/1ps
module tb_mdw_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic       a_in_vld, a_in_rdy, a_upt, a_start, a_res_vld, a_res_rdy, a_res_err;
   logic [3:0] a_in_dat, a_sdat, a_res_dat;
   logic [2:0] a_id;
   logic       a_busy = 1'b0, a_pend = 1'b0;
   logic [3:0] a_fdat = '0;
   logic [3:0] a_tab [5];
   int         a_cnt = 0;

   logic       b_in_vld, b_in_rdy, b_upt, b_start, b_res_vld, b_res_rdy, b_res_err;
   logic [4:0] b_in_dat, b_sdat, b_res_dat;
   logic [4:0] b_id;
   logic       b_busy = 1'b0, b_pend = 1'b0;
   logic [4:0] b_fdat = '0;
   logic [4:0] b_tab [17];
   int         b_cnt = 0;

   mdw_loader #(.W(4), .N(5)) u_a (
      .clk(clk), .rst_n(rst_n), .in_vld(a_in_vld), .in_dat(a_in_dat), .in_rdy(a_in_rdy),
      .state_upt(a_upt), .state_id(a_id), .state_dat(a_sdat), .cntrl_start(a_start),
      .cntrl_busy_r(a_busy), .cntrl_dat_r(a_fdat), .res_vld_r(a_res_vld), .res_rdy(a_res_rdy),
      .res_dat_r(a_res_dat), .res_err_r(a_res_err));

   mdw_loader u_b (
      .clk(clk), .rst_n(rst_n), .in_vld(b_in_vld), .in_dat(b_in_dat), .in_rdy(b_in_rdy),
      .state_upt(b_upt), .state_id(b_id), .state_dat(b_sdat), .cntrl_start(b_start),
      .cntrl_busy_r(b_busy), .cntrl_dat_r(b_fdat), .res_vld_r(b_res_vld), .res_rdy(b_res_rdy),
      .res_dat_r(b_res_dat), .res_err_r(b_res_err));

   function automatic logic [3:0] odd_a();
      for (int i = 0; i < 5; i++) begin
         int c = 0;
         for (int j = 0; j < 5; j++) if (a_tab[j] == a_tab[i]) c++;
         if (c % 2 == 1) return a_tab[i];
      end
      return '0;
   endfunction

   function automatic logic [4:0] odd_b();
      for (int i = 0; i < 17; i++) begin
         int c = 0;
         for (int j = 0; j < 17; j++) if (b_tab[j] == b_tab[i]) c++;
         if (c % 2 == 1) return b_tab[i];
      end
      return '0;
   endfunction

   // Finder models: busy rises two edges after start is seen, stays high three cycles, is not reset.
   always @(posedge clk) begin
      if (a_upt) a_tab[a_id] <= a_sdat;
      if (a_start) begin
         a_pend <= 1'b1; a_busy <= 1'b0; a_fdat <= '0;
      end else if (a_pend) begin
         a_pend <= 1'b0; a_busy <= 1'b1; a_cnt <= 2;
      end else if (a_busy) begin
         if (a_cnt == 0) begin a_busy <= 1'b0; a_fdat <= odd_a(); end
         else a_cnt <= a_cnt - 1;
      end
   end

   always @(posedge clk) begin
      if (b_upt) b_tab[b_id] <= b_sdat;
      if (b_start) begin
         b_pend <= 1'b1; b_busy <= 1'b0; b_fdat <= '0;
      end else if (b_pend) begin
         b_pend <= 1'b0; b_busy <= 1'b1; b_cnt <= 2;
      end else if (b_busy) begin
         if (b_cnt == 0) begin b_busy <= 1'b0; b_fdat <= odd_b(); end
         else b_cnt <= b_cnt - 1;
      end
   end

   int a_ids[$], a_dats[$], b_ids[$], b_dats[$];
   int a_starts = 0, b_starts = 0;

   always @(negedge clk) begin
      if (a_upt) begin a_ids.push_back(int'(a_id)); a_dats.push_back(int'(a_sdat)); end
      if (b_upt) begin b_ids.push_back(int'(b_id)); b_dats.push_back(int'(b_sdat)); end
      if (a_start) a_starts++;
      if (b_start) b_starts++;
   end

   int vec_cnt = 0, mis_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         mis_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge; returns just after the negedge following the transfer.
   task automatic send(input bit sel_b, input logic [4:0] w, input int gap);
      int t = 0;
      if (sel_b) begin b_in_vld = 1'b1; b_in_dat = w; end
      else       begin a_in_vld = 1'b1; a_in_dat = w[3:0]; end
      while (!(sel_b ? b_in_rdy : a_in_rdy) && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) check("in_rdy_timeout", sel_b ? b_in_rdy : a_in_rdy, 1);
      @(negedge clk);
      if (sel_b) b_in_vld = 1'b0; else a_in_vld = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic wait_res(input bit sel_b, output int lat);
      lat = 0;
      while (!(sel_b ? b_res_vld : a_res_vld) && lat < 100) begin @(negedge clk); lat++; end
      check("res_vld_seen", sel_b ? b_res_vld : a_res_vld, 1);
   endtask

   logic [4:0] exp_w [17];

   task automatic check_frame(input bit sel_b, input int base, input int n);
      check("wr_count", sel_b ? b_ids.size() : a_ids.size(), base + n);
      for (int i = 0; i < n; i++) begin
         check("wr_id",  sel_b ? b_ids[base+i]  : a_ids[base+i],  i);
         check("wr_dat", sel_b ? b_dats[base+i] : a_dats[base+i], int'(exp_w[i]));
      end
   endtask

   task automatic set_a(input logic [4:0] w0, w1, w2, w3, w4);
      exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2; exp_w[3] = w3; exp_w[4] = w4;
   endtask

   task automatic send_a_frame(input int gap);
      for (int i = 0; i < 5; i++) send(1'b0, exp_w[i], (i == 4) ? 0 : gap);
   endtask

   int base, st, lat;
   logic exp_err39;

   initial begin
      rst_n = 1'b0;
      a_in_vld = 1'b0; a_in_dat = '0; a_res_rdy = 1'b1;
      b_in_vld = 1'b0; b_in_dat = '0; b_res_rdy = 1'b1;
      repeat (2) @(negedge clk);
      a_in_vld = 1'b1; a_in_dat = 4'd5;
      #1;
      check("rst_res_vld", a_res_vld, 0);
      check("rst_res_dat", a_res_dat, 0);
      check("rst_res_err", a_res_err, 0);
      check("rst_start",   a_start, 0);
      check("rst_upt",     a_upt, 0);
      check("rst_id",      a_id, 0);
      a_in_vld = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rdy_after_rst_a", a_in_rdy, 1);
      check("rdy_after_rst_b", b_in_rdy, 1);

      // Back-to-back frame 3,7,3,9,7
      set_a(3, 7, 3, 9, 7);
      base = a_ids.size(); st = a_starts;
      send_a_frame(0);
      check("start_pulse", a_start, 1);
      check("start_rdy_low", a_in_rdy, 0);
      wait_res(1'b0, lat);
      check("latency", lat, 6);
      check("f1_dat", a_res_dat, 9);
      check("f1_err", a_res_err, 0);
      @(negedge clk);
      check("f1_vld_clear", a_res_vld, 0);
      check("f1_rdy_back", a_in_rdy, 1);
      check("f1_starts", a_starts - st, 1);
      check_frame(1'b0, base, 5);

      // Same frame with one idle cycle between words
      base = a_ids.size(); st = a_starts;
      send_a_frame(1);
      wait_res(1'b0, lat);
      check("f2_dat", a_res_dat, 9);
      check("f2_err", a_res_err, 0);
      @(negedge clk);
      check("f2_starts", a_starts - st, 1);
      check_frame(1'b0, base, 5);

      // Result held under back-pressure; input offered meanwhile must be refused
      set_a(4, 4, 6, 8, 8);
      a_res_rdy = 1'b0;
      base = a_ids.size();
      send_a_frame(0);
      wait_res(1'b0, lat);
      a_in_vld = 1'b1; a_in_dat = 4'd15;
      for (int i = 0; i < 10; i++) begin
         check("hold_vld", a_res_vld, 1);
         check("hold_dat", a_res_dat, 6);
         check("hold_rdy", a_in_rdy, 0);
         @(negedge clk);
      end
      a_in_vld = 1'b0;
      check("hold_no_wr", a_ids.size(), base + 5);
      a_res_rdy = 1'b1;
      @(negedge clk);
      check("hold_release", a_res_vld, 0);

      // Next frame accepted, then reset while the finder is sweeping
      set_a(3, 7, 3, 9, 7);
      base = a_ids.size();
      send_a_frame(0);
      check("f4_wr_count", a_ids.size(), base + 5);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("wrst_vld", a_res_vld, 0);
      check("wrst_dat", a_res_dat, 0);
      check("wrst_start", a_start, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("wrst_rdy", a_in_rdy, 1);
      set_a(1, 1, 2, 2, 5);
      base = a_ids.size(); st = a_starts;
      send_a_frame(0);
      wait_res(1'b0, lat);
      check("f5_dat", a_res_dat, 5);
      check("f5_err", a_res_err, 0);
      @(negedge clk);
      check("f5_starts", a_starts - st, 1);
      check_frame(1'b0, base, 5);

      // Inconsistent frame: finder reports 4, XOR of frame is 7
`ifdef MDW_LOADER_XOR_CHECK_EN
      exp_err39 = 1'b1;
`else
      exp_err39 = 1'b0;
`endif
      set_a(4, 5, 6, 6, 6);
      send_a_frame(0);
      wait_res(1'b0, lat);
      check("f6_dat", a_res_dat, 4);
      check("f6_err", a_res_err, exp_err39);
      @(negedge clk);

      // Default-parameter instance: eight pairs plus 31
      exp_w = '{5'd1, 5'd2, 5'd31, 5'd3, 5'd1, 5'd4, 5'd5, 5'd2, 5'd6,
                5'd3, 5'd7, 5'd8, 5'd4, 5'd5, 5'd6, 5'd8, 5'd7};
      base = b_ids.size(); st = b_starts;
      for (int i = 0; i < 17; i++) send(1'b1, exp_w[i], 0);
      check("b_start_pulse", b_start, 1);
      wait_res(1'b1, lat);
      check("b_dat", b_res_dat, 31);
      check("b_err", b_res_err, 0);
      @(negedge clk);
      check("b_vld_clear", b_res_vld, 0);
      check("b_starts", b_starts - st, 1);
      check_frame(1'b1, base, 17);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
      $finish;
   end

endmodule
